// File: rtl/dti_src_pkg.sv
// Shared types and constants for the DTI pattern source
// and the LFSR used by DTI endpoints.
package dti_src_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DECIDE,
    SEND,
    DONE
  } state_t;

  // Right-shift Galois mask for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] s
  );
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/dti_lfsr16.sv
// 16-bit Galois LFSR with enable and synchronous reload,
// shared by DTI sources and sinks for gap/ready generation.
module dti_lfsr16
  import dti_src_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        reload,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (reload) begin
      state <= seed;
    end else if (en) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/dti_pattern_source.sv
// DTI producer emitting a burst of arithmetic-sequence words
// with optional LFSR-driven valid gaps.
module dti_pattern_source
  import dti_src_pkg::*;
#(
  parameter int          W_DATA    = 64,
  parameter int          W_LEN     = 16,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [W_LEN-1:0]  len,
  input  logic [W_DATA-1:0] base,
  input  logic [W_DATA-1:0] stride,
  input  logic [7:0]        gap_thresh,
  output logic              busy,
  output logic              done,
  output logic [W_LEN-1:0]  sent_cnt,
  output logic [W_DATA-1:0] dout_data,
  output logic              dout_valid,
  input  logic              dout_ready
);

  state_t              state_q;
  state_t              state_d;
  logic [W_LEN-1:0]    len_q;
  logic [W_DATA-1:0]   stride_q;
  logic [W_DATA-1:0]   word_q;
  logic [W_DATA-1:0]   word_nxt;
  logic [15:0]         lfsr_q;
  logic                lfsr_en;
  logic                lfsr_reload;
  logic                hs;
  logic                last;
  logic                gap;
  logic                go;
  logic                go_empty;

  assign hs       = dout_valid & dout_ready;
  assign last     = (sent_cnt + W_LEN'(1)) == len_q;
  assign gap      = lfsr_q[7:0] < gap_thresh;
  assign word_nxt = word_q + stride_q;
  assign go       = start & (len != '0);
  assign go_empty = start & (len == '0);

  dti_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (lfsr_en),
    .reload (lfsr_reload),
    .seed   (LFSR_SEED),
    .state  (lfsr_q)
  );

  always_comb begin
    state_d     = state_q;
    lfsr_en     = 1'b0;
    lfsr_reload = 1'b0;
    unique case (state_q)
      IDLE: begin
        lfsr_reload = go;
        if (go) begin
          state_d = DECIDE;
        end else if (go_empty) begin
          state_d = DONE;
        end
      end
      DECIDE: begin
        lfsr_en = 1'b1;
        if (!gap) begin
          state_d = SEND;
        end
      end
      SEND: begin
        lfsr_en = 1'b1;
        if (hs) begin
          if (last) begin
            state_d = DONE;
          end else if (gap_thresh != 8'd0) begin
            state_d = DECIDE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      sent_cnt   <= '0;
      dout_data  <= '0;
      dout_valid <= 1'b0;
      len_q      <= '0;
      stride_q   <= '0;
      word_q     <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == DECIDE) || (state_d == SEND);
      done    <= (state_d == DONE);
      unique case (state_q)
        IDLE: begin
          if (go) begin
            len_q    <= len;
            stride_q <= stride;
            word_q   <= base;
            sent_cnt <= '0;
          end
        end
        DECIDE: begin
          if (!gap) begin
            dout_valid <= 1'b1;
            dout_data  <= word_q;
          end
        end
        SEND: begin
          if (hs) begin
            sent_cnt <= sent_cnt + W_LEN'(1);
            word_q   <= word_nxt;
            // Zero threshold streams back-to-back without a DECIDE bubble
            if (last || gap_thresh != 8'd0) begin
              dout_valid <= 1'b0;
            end else begin
              dout_data <= word_nxt;
            end
          end
        end
        DONE: begin
        end
      endcase
    end
  end

endmodule

// File: doc/dti_pattern_source.md
# dti_pattern_source

Synthesizable DTI producer that emits a programmed burst of arithmetic-sequence data words on a producer-side DTI port, with optional pseudo-random valid gaps. It is the active transmit end of the DTI handshake. It feeds DUT inputs in on-chip self-test and in simulation harnesses where a DTI spy or consumer sits downstream. Output behaviour satisfies every DTI producer rule: no X on valid, and valid plus data held stable until the handshake.

## Interface
- W_DATA, 64, width of the data word
- W_LEN, 16, width of the burst length and beat counters
- LFSR_SEED, 16'hACE1, reset and reload value of the gap LFSR; must be non-zero
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE
- len  in  W_LEN  number of beats in the burst; latched on start
- base  in  W_DATA  first data word; latched on start
- stride  in  W_DATA  increment between consecutive words; latched on start
- gap_thresh  in  8  gap probability control, sampled each decision cycle; 0 disables gaps, 255 gives a gap on about 255/256 of decision cycles
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the burst completes
- sent_cnt  out  W_LEN  beats handshaken in the current or last burst
- dout_data  out  W_DATA  DTI data
- dout_valid  out  1  DTI valid
- dout_ready  in  1  DTI ready

## Operation
- Reset values: dout_valid=0, dout_data=0, busy=0, done=0, sent_cnt=0, LFSR=LFSR_SEED, state=IDLE.
- States:
  - IDLE:
    - start=1 with len≠0: latch len, base and stride; clear sent_cnt; reload the LFSR; go to DECIDE.
    - start=1 with len=0: go to DONE with no beat issued.
  - DECIDE: a gap is taken when lfsr[7:0] < gap_thresh. Gap: stay in DECIDE with valid low. No gap: assert valid with the current word and go to SEND.
  - SEND: valid and data hold until dout_ready=1.
    - On the handshake: sent_cnt+1 and word += stride.
    - If sent_cnt+1 == len, go to DONE.
    - Otherwise, with gap_thresh==0, the next word is presented in the same cycle (back-to-back) and the state stays SEND. With gap_thresh≠0, valid drops and the state goes to DECIDE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Data arithmetic: word k = base + k*stride modulo 2^W_DATA. It is computed incrementally; overflow wraps silently.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
  - Advances every cycle in DECIDE and SEND; frozen in IDLE and DONE.
- start while busy is ignored. Any cfg change mid-burst is ignored except gap_thresh.
- Gap decisions are made only while valid is low. A gap is never inserted between valid and ready.
- sent_cnt holds its final value after DONE until the next accepted start.

## Timing
- start sampled at edge 0 → earliest dout_valid=1 after edge 1 (one registered cycle through DECIDE, zero gap).
- With gap_thresh=0 and ready held high: handshakes on N consecutive cycles. The last handshake is at cycle N, done is high in cycle N+1, and busy falls in the same cycle.
- len=0: done pulse in the cycle after start; dout_valid never rises.
- Reset asserted mid-burst: all outputs clear asynchronously, the in-flight beat is abandoned, and no done pulse is produced.
- dout_ready is ignored while dout_valid=0; ready may be high in IDLE without effect.

## Structure
- Shared package dti_src_pkg:
  - state enum {IDLE, DECIDE, SEND, DONE};
  - LFSR tap constant;
  - default seed.
- Sub-module dti_lfsr16: enable, reload and seed ports, 16-bit state output. It is reused by future DTI sinks for random ready generation.
- Remaining logic in a single always_ff plus a next-state always_comb. All outputs are driven directly from flops, with no combinational path from dout_ready to dout_valid or dout_data except the back-to-back word update.

## Test plan
- len=4, base=10, stride=3, gap_thresh=0, ready=1 → data 10,13,16,19 on cycles 1–4; done at cycle 5; sent_cnt=4.
- Same config with ready low for 3 cycles at beat 2 → data 16 held stable and valid high throughout the stall. A spy with checks enabled reports no error.
- base=2^64−2, stride=1, len=3 → 2^64−2, 2^64−1, 0.
- len=0, start → done pulse one cycle after start, no valid, busy never high.
- gap_thresh=128, len=1000, random ready → exactly 1000 handshakes and an incrementing sequence. The gap count is nonzero, no gap is taken while valid is high, and two runs produce identical traces (deterministic LFSR).
- rst_n pulsed low at beat 5 of len=10 → valid=0 immediately, no done pulse. A new start then restarts from base with sent_cnt=0.
